// File: rtl/pc_fetch_ctrl_if.sv
// ---------------------------------------------------------------------------
// pc_fetch_ctrl_if
//
// Purpose: groups the harness/decode handshake and the instruction-address
// bus of the program-counter fetch controller into one bundle.
//
// Signals:
//   start        harness -> ctrl  one-cycle pulse to begin or restart execution
//   stall        downstream -> ctrl  freeze pc and state this cycle
//   halt         decode -> ctrl   current instruction is halt
//   jmp          decode -> ctrl   absolute jump/branch taken this cycle
//   target       lookup -> ctrl   absolute jump address (PC_W bits)
//   pc           ctrl -> imem     current instruction address (PC_W bits)
//   fetch_valid  ctrl -> core     pc addresses a live instruction
//   done         ctrl -> harness  program terminated, sticky until start
//   err          ctrl -> harness  termination was out of range, sticky
//   instr_cnt    ctrl -> harness  accepted-fetch count (only when
//                                 PC_FETCH_INSTR_COUNT_EN is defined)
//
// Modports: master = harness/decode side, slave = the controller.
// ---------------------------------------------------------------------------
interface pc_fetch_ctrl_if #(
  parameter int PC_W = 11
);
  logic            start;
  logic            stall;
  logic            halt;
  logic            jmp;
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] pc;
  logic            fetch_valid;
  logic            done;
  logic            err;
`ifdef PC_FETCH_INSTR_COUNT_EN
  logic [15:0]     instr_cnt;
`endif

  modport master (
    output start, stall, halt, jmp, target,
`ifdef PC_FETCH_INSTR_COUNT_EN
    input  instr_cnt,
`endif
    input  pc, fetch_valid, done, err
  );

  modport slave (
    input  start, stall, halt, jmp, target,
`ifdef PC_FETCH_INSTR_COUNT_EN
    output instr_cnt,
`endif
    output pc, fetch_valid, done, err
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// pc_fetch_ctrl
//
// Purpose: program counter and fetch controller for the single-cycle core.
// Holds the current instruction address, advances it sequentially or loads
// an absolute jump target, and runs the start/halt/done sequence with the
// test harness. A downstream stall freezes pc and state.
//
// Ports:
//   CLK      clock, all state changes on the rising edge
//   reset_n  synchronous active-low reset (priority over every input)
//   bus      pc_fetch_ctrl_if.slave: start/stall/halt/jmp/target in,
//            pc/fetch_valid/done/err out (all outputs registered)
//
// Parameters:
//   PC_W        width of pc and jump target
//   PROG_LEN    number of valid instruction words (legal 0..PROG_LEN-1)
//   START_ADDR  address loaded on start and on reset
//
// Optional feature macro: PC_FETCH_INSTR_COUNT_EN adds a 16-bit saturating
// count of accepted fetches on bus.instr_cnt.
// ---------------------------------------------------------------------------
module pc_fetch_ctrl #(
  parameter int              PC_W       = 11,
  parameter int              PROG_LEN   = 1024,
  parameter logic [PC_W-1:0] START_ADDR = '0
) (
  input  logic                CLK,
  input  logic                reset_n,
  pc_fetch_ctrl_if.slave      bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Range checks are done one bit wider than pc so pc+1 cannot wrap silently.
  localparam logic [PC_W:0] PROG_LEN_X = (PC_W+1)'(PROG_LEN);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            fetch_valid_q, fetch_valid_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
`ifdef PC_FETCH_INSTR_COUNT_EN
  logic [15:0]     instr_cnt_q, instr_cnt_d;
`endif

  logic [PC_W:0]   pc_inc;
  logic            pc_inc_ok;
  logic            target_ok;

  assign pc_inc    = {1'b0, pc_q} + (PC_W+1)'(1);
  assign pc_inc_ok = (pc_inc < PROG_LEN_X);
  assign target_ok = ({1'b0, bus.target} < PROG_LEN_X);

  // State register; synchronous reset wins over everything, start included.
  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      pc_q          <= START_ADDR;
      fetch_valid_q <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
`ifdef PC_FETCH_INSTR_COUNT_EN
      instr_cnt_q   <= 16'd0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_valid_q <= fetch_valid_d;
      done_q        <= done_d;
      err_q         <= err_d;
`ifdef PC_FETCH_INSTR_COUNT_EN
      instr_cnt_q   <= instr_cnt_d;
`endif
    end
  end

  // Next-state logic. Everything holds by default, which also covers the
  // stall case in RUN and the sticky done/err in DONE.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fetch_valid_d = fetch_valid_q;
    done_d        = done_q;
    err_d         = err_q;
`ifdef PC_FETCH_INSTR_COUNT_EN
    instr_cnt_d   = instr_cnt_q;
`endif

    case (state_q)
      // IDLE and DONE both wait for start; start restarts from a clean slate.
      IDLE, DONE: begin
        if (bus.start) begin
          state_d       = RUN;
          pc_d          = START_ADDR;
          fetch_valid_d = 1'b1;
          done_d        = 1'b0;
          err_d         = 1'b0;
`ifdef PC_FETCH_INSTR_COUNT_EN
          instr_cnt_d   = 16'd0;
`endif
        end
      end

      // halt beats jmp beats increment; stall ignores decode entirely since
      // decode re-presents halt/jmp once the stall releases.
      RUN: begin
        if (!bus.stall) begin
`ifdef PC_FETCH_INSTR_COUNT_EN
          if (fetch_valid_q && (instr_cnt_q != 16'hFFFF)) begin
            instr_cnt_d = instr_cnt_q + 16'd1;
          end
`endif
          if (bus.halt) begin
            state_d       = DONE;
            fetch_valid_d = 1'b0;
            done_d        = 1'b1;
            err_d         = 1'b0;
          end else if (bus.jmp && target_ok) begin
            pc_d = bus.target;
          end else if (bus.jmp) begin
            state_d       = DONE;
            fetch_valid_d = 1'b0;
            done_d        = 1'b1;
            err_d         = 1'b1;
          end else if (pc_inc_ok) begin
            pc_d = pc_inc[PC_W-1:0];
          end else begin
            state_d       = DONE;
            fetch_valid_d = 1'b0;
            done_d        = 1'b1;
            err_d         = 1'b1;
          end
        end
      end

      default: begin
        state_d       = IDLE;
        pc_d          = START_ADDR;
        fetch_valid_d = 1'b0;
        done_d        = 1'b0;
        err_d         = 1'b0;
      end
    endcase
  end

  assign bus.pc          = pc_q;
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
`ifdef PC_FETCH_INSTR_COUNT_EN
  assign bus.instr_cnt   = instr_cnt_q;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_ctrl
//
// Directed, table-driven bench for pc_fetch_ctrl (PC_W=11, PROG_LEN=1024,
// START_ADDR=0). Each table record holds one cycle of inputs and the
// registered outputs expected after the following rising edge. Reset and
// instruction-count sequences are written out by hand.
// ---------------------------------------------------------------------------
module tb_pc_fetch_ctrl;

  localparam int PC_W = 11;

  typedef struct {
    string            name;
    logic             start;
    logic             stall;
    logic             halt;
    logic             jmp;
    logic [PC_W-1:0]  target;
    logic [PC_W-1:0]  exp_pc;
    logic             exp_fv;
    logic             exp_done;
    logic             exp_err;
  } vec_t;

  logic clk;
  logic reset_n;
  int   n_compared;
  int   n_mismatched;
  vec_t vecs[$];

  pc_fetch_ctrl_if #(.PC_W(PC_W)) bus ();

  pc_fetch_ctrl #(
    .PC_W       (PC_W),
    .PROG_LEN   (1024),
    .START_ADDR (11'd0)
  ) dut (
    .CLK     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic addVec(input string nm, input logic st, input logic sl,
                        input logic hl, input logic jp, input int tg,
                        input int epc, input logic efv, input logic edn,
                        input logic eer);
    vec_t v;
    v.name = nm; v.start = st; v.stall = sl; v.halt = hl; v.jmp = jp;
    v.target = PC_W'(tg); v.exp_pc = PC_W'(epc);
    v.exp_fv = efv; v.exp_done = edn; v.exp_err = eer;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs, clock it, and settle just after the edge.
  task automatic applyStimulus(input logic st, input logic sl, input logic hl,
                               input logic jp, input logic [PC_W-1:0] tg);
    bus.start  = st;
    bus.stall  = sl;
    bus.halt   = hl;
    bus.jmp    = jp;
    bus.target = tg;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string nm, input logic [PC_W-1:0] epc,
                             input logic efv, input logic edn, input logic eer);
    n_compared++;
    if (bus.pc !== epc || bus.fetch_valid !== efv ||
        bus.done !== edn || bus.err !== eer) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got pc=%0d fv=%0b done=%0b err=%0b, want pc=%0d fv=%0b done=%0b err=%0b",
               nm, bus.pc, bus.fetch_valid, bus.done, bus.err, epc, efv, edn, eer);
    end
  endtask

`ifdef PC_FETCH_INSTR_COUNT_EN
  task automatic checkCount(input string nm, input int exp_cnt);
    n_compared++;
    if (bus.instr_cnt !== 16'(exp_cnt)) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got instr_cnt=%0d, want %0d", nm, bus.instr_cnt, exp_cnt);
    end
  endtask
`endif

  initial begin
    n_compared   = 0;
    n_mismatched = 0;

    //     name            st sl hl jp target  pc  fv dn er
    addVec("start",         1, 0, 0, 0,    0,    0, 1, 0, 0);
    addVec("seq1",          0, 0, 0, 0,    0,    1, 1, 0, 0);
    addVec("seq2",          0, 0, 0, 0,    0,    2, 1, 0, 0);
    addVec("seq3",          0, 0, 0, 0,    0,    3, 1, 0, 0);
    addVec("seq4",          0, 0, 0, 0,    0,    4, 1, 0, 0);
    addVec("seq5",          0, 0, 0, 0,    0,    5, 1, 0, 0);
    addVec("jmp492",        0, 0, 0, 1,  492,  492, 1, 0, 0);
    addVec("after_jmp1",    0, 0, 0, 0,    0,  493, 1, 0, 0);
    addVec("after_jmp2",    0, 0, 0, 0,    0,  494, 1, 0, 0);
    addVec("start_in_run",  1, 0, 0, 0,    0,  495, 1, 0, 0);
    addVec("jmp10",         0, 0, 0, 1,   10,   10, 1, 0, 0);
    addVec("stall1",        0, 1, 0, 1,  600,   10, 1, 0, 0);
    addVec("stall2",        0, 1, 0, 1,  600,   10, 1, 0, 0);
    addVec("stall3",        0, 1, 1, 1,  600,   10, 1, 0, 0);
    addVec("unstall",       0, 0, 0, 0,    0,   11, 1, 0, 0);
    addVec("jmp20",         0, 0, 0, 1,   20,   20, 1, 0, 0);
    addVec("halt_and_jmp",  0, 0, 1, 1,    5,   20, 0, 1, 0);
    addVec("done_sticky",   0, 0, 0, 1,    7,   20, 0, 1, 0);
    addVec("restart1",      1, 0, 0, 0,    0,    0, 1, 0, 0);
    addVec("jmp_1100",      0, 0, 0, 1, 1100,    0, 0, 1, 1);
    addVec("err_sticky",    0, 0, 0, 0,    0,    0, 0, 1, 1);
    addVec("restart2",      1, 0, 0, 0,    0,    0, 1, 0, 0);
    addVec("jmp_1024",      0, 0, 0, 1, 1024,    0, 0, 1, 1);
    addVec("restart3",      1, 0, 0, 0,    0,    0, 1, 0, 0);
    addVec("jmp1023",       0, 0, 0, 1, 1023, 1023, 1, 0, 0);
    addVec("stall_at_end",  0, 1, 0, 0,    0, 1023, 1, 0, 0);
    addVec("run_off_end",   0, 0, 0, 0,    0, 1023, 0, 1, 1);
    addVec("restart4",      1, 0, 0, 0,    0,    0, 1, 0, 0);
    addVec("jmp600",        0, 0, 0, 1,  600,  600, 1, 0, 0);

    bus.start  = 1'b0;
    bus.stall  = 1'b0;
    bus.halt   = 1'b0;
    bus.jmp    = 1'b0;
    bus.target = '0;
    reset_n    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_state", 11'd0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;

    // Idle with no start must hold the reset state.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 11'd0);
    checkOutput("idle_hold", 11'd0, 1'b0, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].start, vecs[i].stall, vecs[i].halt,
                    vecs[i].jmp, vecs[i].target);
      checkOutput(vecs[i].name, vecs[i].exp_pc, vecs[i].exp_fv,
                  vecs[i].exp_done, vecs[i].exp_err);
    end

    // Reset while running at pc=600 returns to IDLE.
    reset_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 11'd0);
    checkOutput("reset_mid_run", 11'd0, 1'b0, 1'b0, 1'b0);

    // Reset beats start.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 11'd0);
    checkOutput("reset_with_start", 11'd0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 11'd0);
    checkOutput("idle_after_reset", 11'd0, 1'b0, 1'b0, 1'b0);

    // Reset during a stall also clears everything.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 11'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 11'd300);
    checkOutput("pre_stall_jmp", 11'd300, 1'b1, 1'b0, 1'b0);
    reset_n = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 11'd0);
    checkOutput("reset_mid_stall", 11'd0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;

`ifdef PC_FETCH_INSTR_COUNT_EN
    checkCount("cnt_reset", 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 11'd0);
    checkCount("cnt_start", 0);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 11'd0);
    checkCount("cnt_three", 3);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 11'd0);
    checkCount("cnt_stall", 3);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 11'd492);
    checkCount("cnt_jmp", 4);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 11'd0);
    checkCount("cnt_halt", 5);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 11'd0);
    checkCount("cnt_done_hold", 5);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 11'd0);
    checkCount("cnt_restart", 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
